// File: rtl/main_ori_hist_reader.sv
// main_ori_hist_reader: streams angle codes to main_ori_rom, accumulates magnitudes per returned bin,
// then scans the histogram for the peak bin once per keypoint window.
module main_ori_hist_reader #(
    parameter int ADDR_W = 7,
    parameter int BIN_W  = 6,
    parameter int NBINS  = 36,
    parameter int MAG_W  = 16,
    parameter int ACC_W  = 24
) (
    input  logic              clka,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [ADDR_W-1:0] s_addr,
    input  logic [MAG_W-1:0]  s_mag,
    input  logic              s_last,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [BIN_W-1:0]  rom_dout,
    output logic              ori_valid,
    input  logic              ori_ready,
    output logic [BIN_W-1:0]  ori_bin,
    output logic [ACC_W-1:0]  ori_peak,
    output logic              bin_err,
    output logic              busy
);
    typedef enum logic [1:0] {ACC, DRAIN, SCAN, OUT} state_t;
    localparam logic [BIN_W-1:0] LAST = BIN_W'(NBINS);

    state_t            r_state, w_next;
    logic              r_v1, r_v2, r_drain;
    logic [MAG_W-1:0]  r_mag1, r_mag2;
    logic [BIN_W-1:0]  r_idx, r_best_bin;
    logic [ACC_W-1:0]  r_best_val;
    logic [ACC_W-1:0]  r_hist [NBINS];
    logic              w_accept, w_ok, w_scan_end;
    logic [ACC_W:0]    w_sum;
    logic [ACC_W-1:0]  w_sat, w_cur;

    assign w_accept   = s_valid && s_ready;
    assign w_ok       = rom_dout < LAST;
    assign w_sum      = {1'b0, r_hist[rom_dout]} + {{(ACC_W+1-MAG_W){1'b0}}, r_mag2};
    assign w_sat      = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
    assign w_cur      = r_hist[r_idx];
    // r_idx runs one past the last bin so the result lands an edge after the final compare
    assign w_scan_end = r_idx == LAST;

    always_ff @(posedge clka or posedge rst)
        if (rst) r_state <= ACC;
        else     r_state <= w_next;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ACC:   w_next = (w_accept && s_last) ? DRAIN : ACC;
            DRAIN: w_next = r_drain ? SCAN : DRAIN;
            SCAN:  w_next = w_scan_end ? OUT : SCAN;
            OUT:   w_next = ori_ready ? ACC : OUT;
        endcase
    end

    always_comb begin
        s_ready   = r_state == ACC;
        busy      = r_state != ACC;
        ori_valid = r_state == OUT;
    end

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            r_v1       <= 1'b0;
            r_v2       <= 1'b0;
            r_mag1     <= '0;
            r_mag2     <= '0;
            r_drain    <= 1'b0;
            r_idx      <= '0;
            r_best_bin <= '0;
            r_best_val <= '0;
            rom_addr   <= '0;
            ori_bin    <= '0;
            ori_peak   <= '0;
            bin_err    <= 1'b0;
            for (int i = 0; i < NBINS; i++) r_hist[i] <= '0;
        end else begin
            r_v1 <= w_accept;
            if (w_accept) begin
                rom_addr <= s_addr;
                r_mag1   <= s_mag;
            end
            r_v2   <= r_v1;
            r_mag2 <= r_mag1;
            if (r_v2 && w_ok) r_hist[rom_dout] <= w_sat;
            if (r_v2 && !w_ok) bin_err <= 1'b1;
            r_drain <= (r_state == DRAIN) && !r_drain;
            r_idx   <= (r_state == SCAN) ? r_idx + 1'b1 : '0;
            if (r_state == SCAN && !w_scan_end) begin
                if (w_cur > r_best_val) begin
                    r_best_val <= w_cur;
                    r_best_bin <= r_idx;
                end
                r_hist[r_idx] <= '0;
            end
            if (r_state == SCAN && w_scan_end) begin
                ori_bin  <= r_best_bin;
                ori_peak <= r_best_val;
            end
            if (ori_valid && ori_ready) begin
                r_best_val <= '0;
                r_best_bin <= '0;
            end
        end
    end
endmodule

// File: tb/tb_main_ori_hist_reader.sv
// tb_main_ori_hist_reader: directed windows against a stub ROM, each scenario checks its own results.
module tb_main_ori_hist_reader;
    logic        clka = 0, rst = 1;
    logic        s_valid = 0, s_last = 0, ori_ready = 0, force_bad = 0;
    logic [6:0]  s_addr = 0;
    logic [15:0] s_mag = 0;
    logic        s_ready, ori_valid, bin_err, busy;
    logic [6:0]  rom_addr;
    logic [5:0]  rom_dout = 0, ori_bin;
    logic [23:0] ori_peak;
    int vectors = 0, miscompares = 0;

    main_ori_hist_reader dut (
        .clka(clka), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr),
        .s_mag(s_mag), .s_last(s_last), .rom_addr(rom_addr), .rom_dout(rom_dout),
        .ori_valid(ori_valid), .ori_ready(ori_ready), .ori_bin(ori_bin), .ori_peak(ori_peak),
        .bin_err(bin_err), .busy(busy)
    );

    always #5 clka = ~clka;

    // stub ROM: code 5 maps to bin 3, otherwise code mod 36; force_bad returns an illegal bin
    always @(posedge clka)
        rom_dout <= force_bad ? 6'd40 : (rom_addr == 7'd5 ? 6'd3 : 6'(rom_addr % 7'd36));

    task automatic send(input logic [6:0] a, input logic [15:0] m, input logic l);
        @(negedge clka);
        s_valid = 1; s_addr = a; s_mag = m; s_last = l;
        @(posedge clka);
        #1 s_valid = 0; s_last = 0;
    endtask

    task automatic get_result(output int lat, output logic [5:0] b, output logic [23:0] p);
        lat = 0; b = 'x; p = 'x;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clka);
            #1;
            if (ori_valid) begin
                lat = n; b = ori_bin; p = ori_peak;
                break;
            end
        end
    endtask

    task automatic ack();
        @(negedge clka);
        ori_ready = 1;
        @(posedge clka);
        #1 ori_ready = 0;
    endtask

    task automatic test_reset();
        vectors++;
        if ({s_ready, ori_valid, busy, bin_err} !== 4'b1000 || rom_addr !== 0 || ori_bin !== 0 || ori_peak !== 0) begin
            miscompares++;
            $display("FAIL reset: rdy/vld/busy/err=%b addr=%0d bin=%0d peak=%0d, want 1000/0/0/0",
                     {s_ready, ori_valid, busy, bin_err}, rom_addr, ori_bin, ori_peak);
        end
    endtask

    task automatic test_single();
        int lat; logic [5:0] b; logic [23:0] p;
        send(7'd5, 16'd100, 1);
        vectors++;
        if (rom_addr !== 7'd5 || s_ready !== 0 || busy !== 1) begin
            miscompares++;
            $display("FAIL single_accept: addr=%0d rdy=%b busy=%b, want 5/0/1", rom_addr, s_ready, busy);
        end
        get_result(lat, b, p);
        vectors++;
        if (lat !== 39) begin miscompares++; $display("FAIL single_latency: got %0d want 39", lat); end
        vectors++;
        if (b !== 6'd3 || p !== 24'd100) begin
            miscompares++; $display("FAIL single_result: bin=%0d peak=%0d want 3/100", b, p);
        end
        ack();
        vectors++;
        if (ori_valid !== 0 || s_ready !== 1 || busy !== 0) begin
            miscompares++; $display("FAIL single_ack: vld=%b rdy=%b busy=%b want 0/1/0", ori_valid, s_ready, busy);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic [5:0] b; logic [23:0] p;
        send(7'd7, 16'd10, 0);
        send(7'd7, 16'd20, 0);
        send(7'd7, 16'd30, 0);
        send(7'd7, 16'd40, 1);
        get_result(lat, b, p);
        vectors++;
        if (lat !== 39 || b !== 6'd7 || p !== 24'd100) begin
            miscompares++; $display("FAIL b2b: lat=%0d bin=%0d peak=%0d want 39/7/100", lat, b, p);
        end
        ack();
    endtask

    task automatic test_tie();
        int lat; logic [5:0] b; logic [23:0] p;
        send(7'd2, 16'd50, 0);
        send(7'd9, 16'd50, 1);
        get_result(lat, b, p);
        vectors++;
        if (b !== 6'd2 || p !== 24'd50) begin
            miscompares++; $display("FAIL tie: bin=%0d peak=%0d want 2/50", b, p);
        end
        ack();
        send(7'd9, 16'd1, 1);
        get_result(lat, b, p);
        vectors++;
        if (b !== 6'd9 || p !== 24'd1) begin
            miscompares++; $display("FAIL cleared: bin=%0d peak=%0d want 9/1", b, p);
        end
        ack();
    endtask

    task automatic test_saturation();
        int lat; logic [5:0] b; logic [23:0] p;
        int bad = 0;
        for (int i = 0; i < 300; i++) send(7'd7, 16'hFFFF, i == 299);
        get_result(lat, b, p);
        vectors++;
        if (b !== 6'd7 || p !== 24'hFFFFFF) begin
            miscompares++; $display("FAIL saturate: bin=%0d peak=%h want 7/ffffff", b, p);
        end
        @(negedge clka);
        s_valid = 1; s_addr = 7'd9; s_mag = 16'd5; s_last = 1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clka);
            #1;
            if (ori_valid !== 1 || ori_bin !== 6'd7 || ori_peak !== 24'hFFFFFF || s_ready !== 0) bad++;
        end
        @(negedge clka);
        s_valid = 0; s_last = 0;
        vectors++;
        if (bad != 0) begin miscompares++; $display("FAIL hold: %0d unstable cycles, want 0", bad); end
        ack();
    endtask

    task automatic test_bin_err();
        int lat; logic [5:0] b; logic [23:0] p;
        force_bad = 1;
        send(7'd5, 16'd50, 1);
        get_result(lat, b, p);
        force_bad = 0;
        vectors++;
        if (b !== 6'd0 || p !== 24'd0 || bin_err !== 1) begin
            miscompares++; $display("FAIL bin_err: bin=%0d peak=%0d err=%b want 0/0/1", b, p, bin_err);
        end
        ack();
        vectors++;
        if (bin_err !== 1) begin miscompares++; $display("FAIL err_sticky: err=%b want 1", bin_err); end
    endtask

    task automatic test_reset_mid_scan();
        int lat; logic [5:0] b; logic [23:0] p;
        int seen = 0;
        send(7'd30, 16'd100, 1);
        repeat (10) @(posedge clka);
        #1 rst = 1;
        #2;
        vectors++;
        if (ori_valid !== 0 || s_ready !== 1 || busy !== 0 || bin_err !== 0) begin
            miscompares++;
            $display("FAIL mid_rst: vld=%b rdy=%b busy=%b err=%b want 0/1/0/0", ori_valid, s_ready, busy, bin_err);
        end
        @(negedge clka);
        rst = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clka);
            #1;
            if (ori_valid) seen++;
        end
        vectors++;
        if (seen != 0 || s_ready !== 1) begin
            miscompares++; $display("FAIL no_result: valid cycles=%0d rdy=%b want 0/1", seen, s_ready);
        end
        send(7'd9, 16'd7, 1);
        get_result(lat, b, p);
        vectors++;
        if (lat !== 39 || b !== 6'd9 || p !== 24'd7) begin
            miscompares++; $display("FAIL post_rst: lat=%0d bin=%0d peak=%0d want 39/9/7", lat, b, p);
        end
        ack();
    endtask

    initial begin
        repeat (2) @(posedge clka);
        #1;
        test_reset();
        @(negedge clka);
        rst = 0;
        @(posedge clka);
        #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_tie();
        test_saturation();
        test_bin_err();
        test_reset_mid_scan();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
